// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port round-robin arbiter.
package fifo_write_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int BEAT_W    = 8;
    localparam int MAX_REQ   = 16;
    localparam int MAX_IDX_W = 4;

    // First set bit of valid_vec scanning circularly upward from start_idx,
    // considering only the lowest n_req positions.
    function automatic logic [MAX_IDX_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0]   valid_vec,
        input logic [MAX_IDX_W-1:0] start_idx,
        input int                   n_req
    );
        logic [MAX_IDX_W-1:0] pick;
        int                   idx;
        pick = '0;
        idx  = 0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n_req) begin
                idx = (int'(start_idx) + k) % n_req;
                if (valid_vec[MAX_IDX_W'(idx)]) begin
                    pick = MAX_IDX_W'(idx);
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_priority_pick.sv
// Combinational circular priority encoder used for every arbitration decision.
module fifo_write_arbiter_rr_priority_pick
    import fifo_write_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_vec,
    input  logic [IDX_W-1:0] start_idx,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_any
);

    logic [MAX_REQ-1:0]   validPad;
    logic [MAX_IDX_W-1:0] pickFull;

    always_comb begin
        validPad              = '0;
        validPad[N_REQ-1:0]   = valid_vec;
        pickFull              = rr_pick(validPad, MAX_IDX_W'(start_idx), N_REQ);
    end

    assign pick_idx = IDX_W'(pickFull);
    assign pick_any = |valid_vec;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between N_REQ requesters;
// words pass combinationally to the FIFO only while it is not full.
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clk_write,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ-1:0]              req_last,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]              req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_write,
    output logic [DATA_WIDTH-1:0]         fifo_data_write,
    output logic                          grant_valid,
    output logic [$clog2(N_REQ)-1:0]      grant_id,
    output logic [7:0]                    beat_cnt
);

    localparam int ID_W = $clog2(N_REQ);

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   grantId_q, grantId_d;
    logic [ID_W-1:0]   lastId_q, lastId_d;
    logic [BEAT_W-1:0] beatCnt_q, beatCnt_d;

    logic [N_REQ-1:0]  grantMask;
    logic [N_REQ-1:0]  pickValid;
    logic [ID_W-1:0]   pickStart;
    logic [ID_W-1:0]   pickIdx;
    logic              pickAny;
    logic              xfer;
    logic              burstDone;

    always_comb begin
        grantMask       = '0;
        fifo_data_write = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == grantId_q) begin
                grantMask[i]    = 1'b1;
                fifo_data_write = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign xfer      = (state_q == GRANT) && (|(req_valid & grantMask)) && !fifo_full;
    assign burstDone = xfer && ((|(req_last & grantMask)) ||
                                (beatCnt_q == BEAT_W'(MAX_BURST - 1)));

    assign fifo_write  = xfer;
    assign req_ready   = xfer ? grantMask : '0;
    assign grant_valid = (state_q == GRANT);
    assign grant_id    = grantId_q;
    assign beat_cnt    = beatCnt_q;

    // lastId_q tracks the current holder while granted, so one rotation base
    // serves both the idle pick and the release re-pick; the holder is masked out.
    assign pickValid = (state_q == GRANT) ? (req_valid & ~grantMask) : req_valid;
    assign pickStart = (lastId_q == ID_W'(N_REQ - 1)) ? '0 : lastId_q + ID_W'(1);

    fifo_write_arbiter_rr_priority_pick #(
        .N_REQ (N_REQ),
        .IDX_W (ID_W)
    ) rr_priority_pick (
        .valid_vec (pickValid),
        .start_idx (pickStart),
        .pick_idx  (pickIdx),
        .pick_any  (pickAny)
    );

    always_comb begin
        state_d   = state_q;
        grantId_d = grantId_q;
        lastId_d  = lastId_q;
        beatCnt_d = beatCnt_q;
        case (state_q)
            IDLE: begin
                if (pickAny) begin
                    state_d   = GRANT;
                    grantId_d = pickIdx;
                    lastId_d  = pickIdx;
                    beatCnt_d = '0;
                end
            end
            GRANT: begin
                if (burstDone) begin
                    beatCnt_d = '0;
                    if (pickAny) begin
                        grantId_d = pickIdx;
                        lastId_d  = pickIdx;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    beatCnt_d = beatCnt_q + BEAT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk_write or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grantId_q <= '0;
            lastId_q  <= ID_W'(N_REQ - 1);
            beatCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grantId_q <= grantId_d;
            lastId_q  <= lastId_d;
            beatCnt_q <= beatCnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomised scoreboard bench for fifo_write_arbiter: requester words are queued
// per source and a negedge monitor checks every cycle against a burst-level model.
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            clk_write = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_write;
    logic [DW-1:0]   fifo_data_write;
    logic            grant_valid;
    logic [1:0]      grant_id;
    logic [7:0]      beat_cnt;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    word_t    srcQ[N][$];
    word_t    expQ[N][$];
    word_t    cur[N];
    bit       presenting[N];
    int       dropCnt[N];
    int       seqNo[N];
    int       gapPct;
    int       fullPct;
    bit       fullForce;
    logic [N-1:0] acceptMask;

    int compared   = 0;
    int mismatched = 0;

    int mHolder;
    int mLast;
    int mBeats;

    fifo_write_arbiter #(
        .N_REQ      (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk_write       (clk_write),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_last        (req_last),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .fifo_full       (fifo_full),
        .fifo_write      (fifo_write),
        .fifo_data_write (fifo_data_write),
        .grant_valid     (grant_valid),
        .grant_id        (grant_id),
        .beat_cnt        (beat_cnt)
    );

    always #5 clk_write = ~clk_write;

    function automatic int rrPick(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic driveInputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = presenting[i] && (dropCnt[i] == 0);
            req_last[i]            = cur[i].last;
            req_data[i*DW +: DW]   = cur[i].data;
        end
    endtask

    task automatic addPacket(input int id, input int len);
        word_t w;
        for (int k = 0; k < len; k++) begin
            w.data = {id[1:0], seqNo[id][5:0]};
            w.last = (k == len - 1);
            seqNo[id]++;
            srcQ[id].push_back(w);
        end
    endtask

    // One clock: retire accepted words, present new ones, then drive the pins.
    task automatic applyStimulus();
        @(posedge clk_write);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acceptMask[i]) presenting[i] = 1'b0;
            if (dropCnt[i] > 0) dropCnt[i]--;
            if (!presenting[i] && srcQ[i].size() > 0 && $urandom_range(99) >= gapPct) begin
                cur[i]        = srcQ[i].pop_front();
                presenting[i] = 1'b1;
                expQ[i].push_back(cur[i]);
            end
        end
        fifo_full = fullForce || ($urandom_range(99) < fullPct);
        driveInputs();
    endtask

    function automatic bit allDrained();
        for (int i = 0; i < N; i++) begin
            if (srcQ[i].size() != 0 || expQ[i].size() != 0 || presenting[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic runUntilDrained(input int maxCycles);
        int n;
        n = 0;
        while (!allDrained() && n < maxCycles) begin
            applyStimulus();
            n++;
        end
        if (!allDrained()) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain_timeout: actual=not drained after %0d cycles required=drained", n);
        end
        for (int k = 0; k < 3; k++) applyStimulus();
    endtask

    task automatic checkResetValues();
        checkOutput("rst_fifo_write", fifo_write, 0);
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_grant_valid", grant_valid, 0);
        checkOutput("rst_grant_id", grant_id, 0);
        checkOutput("rst_beat_cnt", beat_cnt, 0);
    endtask

    // Burst-level reference: holder, rotation pointer and beat count advance
    // from the words the bench itself presented and the full level it drove.
    always @(negedge clk_write) begin : monitor
        logic [N-1:0] vis;
        logic [N-1:0] others;
        bit           xferExp;
        word_t        w;
        if (!rst_n) begin
            mHolder    = -1;
            mLast      = N - 1;
            mBeats     = 0;
            acceptMask = '0;
        end else begin
            acceptMask = req_ready;
            vis        = req_valid;
            checkOutput("grant_valid", grant_valid, mHolder >= 0);
            if (mHolder >= 0) begin
                checkOutput("grant_id", grant_id, mHolder);
                checkOutput("beat_cnt", beat_cnt, mBeats);
            end
            xferExp = (mHolder >= 0) && vis[mHolder] && !fifo_full;
            checkOutput("fifo_write", fifo_write, xferExp);
            checkOutput("req_ready", req_ready, xferExp ? (1 << mHolder) : 0);
            if (xferExp) begin
                if (expQ[mHolder].size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL scoreboard: actual=transfer from %0d required=no pending word", mHolder);
                end else begin
                    w = expQ[mHolder].pop_front();
                    checkOutput("fifo_data_write", fifo_data_write, w.data);
                    mBeats++;
                    if (w.last || mBeats == MB) begin
                        others          = vis;
                        others[mHolder] = 1'b0;
                        mBeats          = 0;
                        if (others != 0) begin
                            mHolder = rrPick(others, (mHolder + 1) % N);
                            mLast   = mHolder;
                        end else begin
                            mHolder = -1;
                        end
                    end
                end
            end else if (mHolder < 0 && vis != 0) begin
                mHolder = rrPick(vis, (mLast + 1) % N);
                mLast   = mHolder;
                mBeats  = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            presenting[i] = 1'b0;
            dropCnt[i]    = 0;
            seqNo[i]      = 0;
            cur[i]        = '0;
        end
        gapPct    = 0;
        fullPct   = 0;
        fullForce = 1'b0;
        fifo_full = 1'b0;
        rst_n     = 1'b0;
        driveInputs();
        #2;
        checkResetValues();
        applyStimulus();
        applyStimulus();
        rst_n = 1'b1;

        $display("[TB] single requester packet");
        addPacket(2, 3);
        runUntilDrained(50);

        $display("[TB] three requesters, round-robin order");
        addPacket(0, 2);
        addPacket(1, 2);
        addPacket(3, 2);
        addPacket(0, 2);
        runUntilDrained(100);

        $display("[TB] forced release at MAX_BURST");
        addPacket(1, 10);
        addPacket(2, 1);
        addPacket(2, 1);
        runUntilDrained(100);

        $display("[TB] fifo full mid-burst");
        addPacket(3, 4);
        applyStimulus();
        applyStimulus();
        applyStimulus();
        fullForce = 1'b1;
        for (int k = 0; k < 5; k++) applyStimulus();
        fullForce = 1'b0;
        runUntilDrained(50);

        $display("[TB] granted requester drops valid");
        addPacket(0, 4);
        addPacket(1, 2);
        applyStimulus();
        applyStimulus();
        dropCnt[0] = 3;
        driveInputs();
        runUntilDrained(100);

        $display("[TB] reset mid-burst");
        for (int i = 0; i < N; i++) addPacket(i, 4);
        applyStimulus();
        applyStimulus();
        applyStimulus();
        rst_n = 1'b0;
        #1;
        checkResetValues();
        applyStimulus();
        applyStimulus();
        rst_n = 1'b1;
        runUntilDrained(200);

        $display("[TB] randomised traffic");
        gapPct  = 30;
        fullPct = 20;
        for (int p = 0; p < 40; p++) addPacket($urandom_range(N - 1), $urandom_range(1, 6));
        runUntilDrained(3000);
        gapPct  = 0;
        fullPct = 0;
        applyStimulus();

        for (int i = 0; i < N; i++) checkOutput("exp_queue_empty", expQ[i].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the write port of the asynchronous FIFO between `N_REQ` requesters in the `clk_write` domain. It grants one requester at a time and holds the grant for a burst, which ends on `req_last` or after `MAX_BURST` words. It forwards that requester's words to the FIFO only while the FIFO is not full, so no write is ever dropped. It sits directly in front of the FIFO's `write`/`data_write`/`full` pins.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 8: word width; must equal the FIFO `DATA_WIDTH`.
- `MAX_BURST`, 16: maximum words per grant, 1..255.

Ports:
- `clk_write`  in  1  write-domain clock; every register here is clocked by it.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  N_REQ  per-requester word valid.
- `req_last`  in  N_REQ  per-requester last word of a burst.
- `req_data`  in  N_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  N_REQ  per-requester accept, one-hot or zero.
- `fifo_full`  in  1  FIFO `full`, already synchronous to `clk_write`.
- `fifo_write`  out  1  to FIFO `write`.
- `fifo_data_write`  out  DATA_WIDTH  to FIFO `data_write`.
- `grant_valid`  out  1  a grant is held (state GRANT).
- `grant_id`  out  $clog2(N_REQ)  index of the held or most recent grant.
- `beat_cnt`  out  8  words transferred in the current grant.

## Operation
- States: IDLE and GRANT.
- **IDLE**
  - If any `req_valid` is high, select the winner by scanning circularly from (`last_id`+1) mod `N_REQ`; the first valid requester wins.
  - Register `grant_id`=winner and `last_id`=winner, clear `beat_cnt`, go to GRANT.
  - No transfer occurs in IDLE.
- **GRANT**, with g = `grant_id`
  - Transfer condition: xfer = `req_valid[g]` && !`fifo_full`.
  - `fifo_write` = xfer. `req_ready[g]` = xfer. All other `req_ready` bits are 0.
  - `fifo_data_write` = `req_data` slice g, combinational, in all states. It is don't-care when `fifo_write`=0.
  - On xfer, `beat_cnt` increments by 1.
  - Release when xfer && (`req_last[g]` || `beat_cnt`==`MAX_BURST`-1).
  - On release with other valid requests present (excluding g in the same cycle): re-arbitrate immediately from g+1 and stay in GRANT with the new winner and `beat_cnt`=0. There is no idle bubble.
  - On release with no other valid request: go to IDLE.
- **Requester rules**
  - Valid-ready semantics: once `req_valid` rises, it and `req_data` stay stable until the word is accepted.
  - A requester whose `req_valid` drops while granted keeps the grant. The arbiter waits; there is no timeout.
- **Full handling**: while `fifo_full`=1, `fifo_write`=0, every `req_ready`=0, `beat_cnt` holds and the grant is held.
- **Forced release**: a `MAX_BURST` release splits a packet. The requester re-competes and continues the packet on its next grant. Words are never reordered within a requester.
- **Reset values**: state IDLE, `grant_valid`=0, `grant_id`=0, `last_id`=`N_REQ`-1 (so requester 0 wins first), `beat_cnt`=0, `fifo_write`=0, `req_ready`=0.
- **Reset mid-burst**: a partial burst is abandoned. Words already written remain in the FIFO.

## Timing
- Arbitration latency from IDLE: `req_valid` seen at edge k gives `grant_valid`=1 after edge k, and the first transfer can occur in that same cycle, which ends at edge k+1.
- Back-to-back grants: zero-cycle gap. The last word of requester A and the first word of requester B occupy consecutive cycles.
- Throughput: 1 word per cycle while not full.
- Combinational paths:
  - `fifo_full` to `fifo_write`/`req_ready`.
  - `req_valid` to `fifo_write`/`req_ready`.
  - `req_data` to `fifo_data_write`.
- No combinational path from `req_ready` back into the arbiter state.
- The FIFO's registered `full` may lag by one write. Correctness relies on the FIFO also gating `write` with `full`.

## Structure
- Shared package holds:
  - the state enum {IDLE, GRANT};
  - `BEAT_W`=8;
  - a function `rr_pick(valid_vec, start_idx)` that returns the first set index scanning circularly from `start_idx`.
- One sub-module is natural: `rr_priority_pick`, a combinational circular priority encoder with ports valid_vec, start_idx, pick_idx, pick_any. It is used for both the IDLE pick and the release re-pick.
- The remainder is the state register, grant/`beat_cnt` registers, output mux and `req_ready` decode.

## Test plan
- Reset, then requester 2 sends 3 words A1,A2,A3 with `req_last` on A3 -> grant to 2 one cycle after valid; FIFO receives A1..A3 on consecutive cycles; return to IDLE.
- Requesters 0, 1 and 3 all valid with 2-word packets -> grant order 0, 1, 3, 0; no idle cycle between packets.
- `MAX_BURST`=4, requester 1 streams 10 words with `req_last`=0 and requester 2 valid -> grants 1(4 words), 2, 1(4 words), 2, 1(2 words); data order is preserved per requester.
- `fifo_full` asserted for 5 cycles mid-burst -> `fifo_write`=0, `req_ready`=0, `beat_cnt` frozen for those 5 cycles; the burst resumes with no loss or duplicate.
- Granted requester drops `req_valid` for 3 cycles -> grant held, no writes, no re-arbitration; resumes afterwards.
- `rst_n` pulsed low mid-burst -> outputs go to reset values immediately; after release, requester 0 wins first when all requesters are valid.
